// File: rtl/pseudo_linear_trainer.sv
// Single-sample binary linear classifier with chunked popcount evaluation and a
// per-bit parameter update that flips bits whose toggle alone would change the decision.
module pseudo_linear_trainer #(
    parameter int unsigned N_BITS       = 784,
    parameter int unsigned CHUNK        = 16,
    parameter int unsigned THRESH_SHIFT = 2,
    localparam int unsigned CW          = $clog2(N_BITS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [N_BITS-1:0] in_data_i,
    input  logic              in_label_i,
    input  logic              in_train_i,
    input  logic              p_load_i,
    input  logic [N_BITS-1:0] p_load_data_i,
    output logic              out_valid_o,
    output logic              out_result_o,
    output logic              out_err_o,
    output logic              out_updated_o,
    output logic [CW-1:0]     out_flips_o,
    output logic [N_BITS-1:0] p_out_o
);
    localparam int unsigned NCH = N_BITS / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {StIdle, StCount, StEval, StUpdate, StDone} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_BITS-1:0]   x_q, x_d, p_q, p_d;
    logic                label_q, label_d, train_q, train_d, res_q, res_d;
    logic [CW-1:0]       num_q, num_d, nump_q, nump_d, flips_q, flips_d;
    logic                out_result_q, out_result_d, out_err_q, out_err_d;
    logic                out_updated_q, out_updated_d;
    logic [CW-1:0]       out_flips_q, out_flips_d;

    logic [31:0]         base;
    logic [CHUNK-1:0]    x_c, p_c, re_c;
    logic [CW-1:0]       and_cnt, p_cnt, flip_cnt, n_m, np_m;
    logic                last_chunk, eval_res;

    function automatic logic thresh(input logic [CW-1:0] n, input logic [CW-1:0] np);
        return (np >> THRESH_SHIFT) >= n;
    endfunction

    assign base       = 32'(idx_q) * CHUNK;
    assign x_c        = x_q[base +: CHUNK];
    assign p_c        = p_q[base +: CHUNK];
    assign last_chunk = (idx_q == IW'(NCH - 1));
    assign eval_res   = thresh(num_q, nump_q);

    // Per-bit candidates are always taken against the COUNT snapshot, so chunking is invisible.
    always_comb begin
        and_cnt  = '0;
        p_cnt    = '0;
        flip_cnt = '0;
        re_c     = '0;
        n_m      = '0;
        np_m     = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            and_cnt = and_cnt + CW'(x_c[i] & p_c[i]);
            p_cnt   = p_cnt + CW'(p_c[i]);
            n_m     = num_q;
            if (x_c[i] && !p_c[i]) n_m = num_q + CW'(1);
            else if (x_c[i] && p_c[i]) n_m = num_q - CW'(1);
            np_m     = p_c[i] ? nump_q - CW'(1) : nump_q + CW'(1);
            re_c[i]  = res_q ^ thresh(n_m, np_m);
            flip_cnt = flip_cnt + CW'(re_c[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            x_q           <= '0;
            p_q           <= '0;
            label_q       <= 1'b0;
            train_q       <= 1'b0;
            res_q         <= 1'b0;
            num_q         <= '0;
            nump_q        <= '0;
            flips_q       <= '0;
            out_result_q  <= 1'b0;
            out_err_q     <= 1'b0;
            out_updated_q <= 1'b0;
            out_flips_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            x_q           <= x_d;
            p_q           <= p_d;
            label_q       <= label_d;
            train_q       <= train_d;
            res_q         <= res_d;
            num_q         <= num_d;
            nump_q        <= nump_d;
            flips_q       <= flips_d;
            out_result_q  <= out_result_d;
            out_err_q     <= out_err_d;
            out_updated_q <= out_updated_d;
            out_flips_q   <= out_flips_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_valid_i) state_d = StCount;
            StCount:  if (last_chunk) state_d = StEval;
            StEval:   state_d = (train_q && (eval_res ^ label_q)) ? StUpdate : StDone;
            StUpdate: if (last_chunk) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_o    = (state_q == StIdle);
        out_valid_o   = (state_q == StDone);
        out_result_o  = out_result_q;
        out_err_o     = out_err_q;
        out_updated_o = out_updated_q;
        out_flips_o   = out_flips_q;
        p_out_o       = p_q;
    end

    always_comb begin
        idx_d         = idx_q;
        x_d           = x_q;
        p_d           = p_q;
        label_d       = label_q;
        train_d       = train_q;
        res_d         = res_q;
        num_d         = num_q;
        nump_d        = nump_q;
        flips_d       = flips_q;
        out_result_d  = out_result_q;
        out_err_d     = out_err_q;
        out_updated_d = out_updated_q;
        out_flips_d   = out_flips_q;
        unique case (state_q)
            StIdle: begin
                // A load on the accept edge lands before COUNT reads p.
                if (p_load_i) p_d = p_load_data_i;
                if (in_valid_i) begin
                    x_d     = in_data_i;
                    label_d = in_label_i;
                    train_d = in_train_i;
                    num_d   = '0;
                    nump_d  = '0;
                    flips_d = '0;
                    idx_d   = '0;
                end
            end
            StCount: begin
                num_d  = num_q + and_cnt;
                nump_d = nump_q + p_cnt;
                idx_d  = last_chunk ? '0 : idx_q + IW'(1);
            end
            StEval: begin
                res_d = eval_res;
                if (!(train_q && (eval_res ^ label_q))) begin
                    out_result_d  = eval_res;
                    out_err_d     = eval_res ^ label_q;
                    out_updated_d = 1'b0;
                    out_flips_d   = '0;
                end
            end
            StUpdate: begin
                p_d[base +: CHUNK] = p_c ^ re_c;
                flips_d = flips_q + flip_cnt;
                idx_d   = last_chunk ? '0 : idx_q + IW'(1);
                if (last_chunk) begin
                    out_result_d  = res_q;
                    out_err_d     = res_q ^ label_q;
                    out_flips_d   = flips_d;
                    out_updated_d = (flips_d != '0);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pseudo_linear_trainer.sv
// Randomized bench for pseudo_linear_trainer (N_BITS=8, CHUNK=4) against a whole-vector
// reference model of the classify/update rules.
module tb_pseudo_linear_trainer;
    localparam int NB  = 8;
    localparam int CH  = 4;
    localparam int NCH = NB / CH;
    localparam int CW  = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] in_data = '0;
    logic          in_label = 1'b0;
    logic          in_train = 1'b0;
    logic          p_load = 1'b0;
    logic [NB-1:0] p_load_data = '0;
    logic          out_valid, out_result, out_err, out_updated;
    logic [CW-1:0] out_flips;
    logic [NB-1:0] p_out;

    int            checks = 0;
    int            fails = 0;
    logic [NB-1:0] mp = '0;

    pseudo_linear_trainer #(.N_BITS(NB), .CHUNK(CH), .THRESH_SHIFT(2)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_label_i(in_label), .in_train_i(in_train),
        .p_load_i(p_load), .p_load_data_i(p_load_data), .out_valid_o(out_valid),
        .out_result_o(out_result), .out_err_o(out_err), .out_updated_o(out_updated),
        .out_flips_o(out_flips), .p_out_o(p_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Whole-vector reference: decision, then every bit judged against the untouched counts.
    task automatic model(input logic [NB-1:0] p, input logic [NB-1:0] x, input bit label,
                         input bit train, output bit res, output bit err, output int flips,
                         output logic [NB-1:0] pn);
        int num, nump, n2, np2;
        bit r;
        num   = $countones(p & x);
        nump  = $countones(p);
        res   = ((nump >> 2) >= num);
        err   = (res != label);
        pn    = p;
        flips = 0;
        if (train && err) begin
            for (int m = 0; m < NB; m++) begin
                n2  = num + ((x[m] && !p[m]) ? 1 : 0) - ((x[m] && p[m]) ? 1 : 0);
                np2 = p[m] ? nump - 1 : nump + 1;
                r   = res ^ ((np2 >> 2) >= n2);
                pn[m] = p[m] ^ r;
                flips += int'(r);
            end
        end
    endtask

    task automatic run_sample(input logic [NB-1:0] x, input bit label, input bit train,
                              input bit load, input logic [NB-1:0] ld, input string tag);
        bit er, ee;
        int ef, n, elat;
        logic [NB-1:0] ep;
        if (load) mp = ld;
        model(mp, x, label, train, er, ee, ef, ep);
        elat = (train && ee) ? 2 * NCH + 2 : NCH + 2;
        in_data = x; in_label = label; in_train = train;
        p_load = load; p_load_data = ld; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs while busy; a stray load must be ignored.
        in_valid = 1'b0; in_data = NB'($urandom); in_label = ~label;
        in_train = 1'($urandom); p_load = 1'b1; p_load_data = NB'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            p_load = 1'b0;
        end while (!out_valid && n < 40);
        checks++;
        if (!out_valid) begin
            fails++;
            $display("FAIL %s timeout: out_valid=%0b after %0d cycles, required 1", tag, out_valid, n);
        end
        checks++;
        if (n + 1 != elat) begin
            fails++;
            $display("FAIL %s latency: got %0d required %0d", tag, n + 1, elat);
        end
        checks++;
        if (out_result !== er || out_err !== ee) begin
            fails++;
            $display("FAIL %s result/err: got %0b/%0b required %0b/%0b", tag, out_result, out_err, er, ee);
        end
        checks++;
        if (out_flips !== CW'(ef) || out_updated !== (ef != 0)) begin
            fails++;
            $display("FAIL %s flips/updated: got %0d/%0b required %0d/%0b", tag, out_flips,
                     out_updated, ef, ef != 0);
        end
        checks++;
        if (p_out !== ep) begin
            fails++;
            $display("FAIL %s p_out: got %h required %h", tag, p_out, ep);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== er || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s strobe/hold: valid=%0b result=%0b ready=%0b required 0/%0b/1", tag,
                     out_valid, out_result, in_ready, er);
        end
        mp = ep;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mp = '0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p_out !== '0) begin
            fails++;
            $display("FAIL reset_state: ready=%0b valid=%0b p=%h required 1/0/00", in_ready, out_valid, p_out);
        end
        checks++;
        if (out_result !== 1'b0 || out_err !== 1'b0 || out_updated !== 1'b0 || out_flips !== '0) begin
            fails++;
            $display("FAIL reset_outputs: %0b %0b %0b %0d required all 0", out_result, out_err,
                     out_updated, out_flips);
        end
    endtask

    task automatic test_directed();
        run_sample(8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, "no_update");
        run_sample(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, "full_flip");
        p_load = 1'b1; p_load_data = 8'hFF;
        @(posedge clk); #1;
        p_load = 1'b0;
        mp = 8'hFF;
        checks++;
        if (p_out !== 8'hFF) begin
            fails++;
            $display("FAIL idle_load: p_out=%h required ff", p_out);
        end
        run_sample(8'h0F, 1'b0, 1'b1, 1'b0, 8'h00, "loaded_eval");
        run_sample(8'h0F, 1'b0, 1'b0, 1'b1, 8'h00, "infer_err");
    endtask

    task automatic test_held_valid();
        bit er, ee;
        int ef, ns;
        int pos[4];
        logic [NB-1:0] ep;
        model(mp, 8'h5A, 1'b1, 1'b0, er, ee, ef, ep);
        in_data = 8'h5A; in_label = 1'b1; in_train = 1'b0; in_valid = 1'b1;
        ns = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (ns < 4) pos[ns] = c;
                ns++;
                checks++;
                if (out_result !== er || out_updated !== 1'b0) begin
                    fails++;
                    $display("FAIL held_result: got %0b/%0b required %0b/0", out_result, out_updated, er);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (ns != 3) begin
            fails++;
            $display("FAIL held_count: %0d strobes required 3", ns);
        end else begin
            checks++;
            if (pos[0] != NCH + 2 || pos[1] - pos[0] != NCH + 3 || pos[2] - pos[1] != NCH + 3) begin
                fails++;
                $display("FAIL held_spacing: strobes at %0d,%0d,%0d required %0d,%0d,%0d", pos[0],
                         pos[1], pos[2], NCH + 2, 2 * NCH + 5, 3 * NCH + 8);
            end
        end
        checks++;
        if (p_out !== mp) begin
            fails++;
            $display("FAIL held_p: p_out=%h required %h", p_out, mp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_sample(NB'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(3) == 0),
                       NB'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_update();
        int seen;
        in_data = 8'hFF; in_label = 1'b0; in_train = 1'b1;
        p_load = 1'b1; p_load_data = 8'h00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; p_load = 1'b0;
        repeat (NCH + 2) @(posedge clk);
        #1 rst = 1'b1;
        mp = '0;
        #1;
        checks++;
        if (p_out !== '0 || out_valid !== 1'b0 || out_flips !== '0) begin
            fails++;
            $display("FAIL midupd_reset: p=%h valid=%0b flips=%0d required 00/0/0", p_out, out_valid, out_flips);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || p_out !== '0) begin
            fails++;
            $display("FAIL midupd_release: ready=%0b p=%h required 1/00", in_ready, p_out);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midupd_novalid: %0d strobes required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_held_valid();
        test_random();
        test_reset_mid_update();
        run_sample(8'hC3, 1'b0, 1'b1, 1'b0, 8'h00, "post_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
